// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single memory port between instruction fetch (IFU, read-only) and
// load/store (LSU, read/write). One transaction is in flight at a time. An
// accepted request waits LATENCY cycles (SRAM delay model), then drives exactly
// one single-cycle memory access. The result goes back on the owner's response
// channel.
//
// Valid/ready contract (all four channels): a transfer happens in a cycle where
// valid and ready are both 1 at the rising edge. A source holds its payload
// stable while valid is high and not yet accepted. req_ready is a combinational
// function of state and the req_valid inputs only. resp_valid and rdata stay
// stable until the owner's resp_ready completes the transfer.
//
// Parameters:
//   LATENCY   cycles from request acceptance to the memory access (1..15)
//   LSU_PRIO  1: LSU wins ties; 0: round-robin on ties
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   ifu_req_valid/ready, ifu_raddr  IFU read request channel
//   ifu_resp_valid/ready, ifu_rdata IFU response channel
//   lsu_req_valid/ready, lsu_wen,
//   lsu_addr, lsu_wdata, lsu_wmask  LSU request channel
//   lsu_resp_valid/ready, lsu_rdata LSU response channel (rdata 0 for writes)
//   mem_valid, mem_wen, mem_raddr,
//   mem_waddr, mem_wdata, mem_wmask memory access strobe and payload
//   mem_rdata                       combinational read data from memory
//   state_dbg                       current FSM state (IDLE=0 WAIT=1 ACCESS=2 RESP=3)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int LATENCY  = 1,
  parameter bit LSU_PRIO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_raddr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [7:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [31:0] lsu_rdata,
  output logic        mem_valid,
  output logic        mem_wen,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic        owner_lsu;
  logic        last_lsu;
  logic        wen_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [7:0]  wmask_q;
  logic [31:0] rdata_q;
  logic        grant_lsu;
  logic        grant_ifu;
  logic        req_hs;
  logic        resp_hs;

  // LSU takes the grant when alone, when it has fixed priority, or on a
  // round-robin tie when the IFU was granted last.
  assign grant_lsu = lsu_req_valid & (~ifu_req_valid | LSU_PRIO | ~last_lsu);
  assign grant_ifu = ifu_req_valid & ~grant_lsu;

  assign ifu_req_ready = (state == IDLE) & grant_ifu;
  assign lsu_req_ready = (state == IDLE) & grant_lsu;
  assign req_hs        = ifu_req_ready | lsu_req_ready;
  assign resp_hs       = (state == RESP) & (owner_lsu ? lsu_resp_ready : ifu_resp_ready);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_hs) state_next = (LATENCY > 1) ? WAIT : ACCESS;
      // The counter is decremented on this edge; leaving when it reads 1
      // means it reaches 0 exactly as ACCESS begins, LATENCY cycles after
      // the request handshake.
      WAIT:    if (cnt == 4'd1) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    if (resp_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      owner_lsu <= 1'b0;
      last_lsu  <= 1'b0;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req_hs) begin
            owner_lsu <= grant_lsu;
            last_lsu  <= grant_lsu;
            // The IFU path is read-only, so its write payload is forced to 0.
            wen_q     <= grant_lsu & lsu_wen;
            addr_q    <= grant_lsu ? lsu_addr : ifu_raddr;
            wdata_q   <= grant_lsu ? lsu_wdata : '0;
            wmask_q   <= grant_lsu ? lsu_wmask : '0;
            cnt       <= CNT_LOAD;
          end
        end
        WAIT:    cnt <= cnt - 4'd1;
        ACCESS:  rdata_q <= wen_q ? '0 : mem_rdata;
        default: ;
      endcase
    end
  end

  // Memory outputs are gated to 0 outside ACCESS so the memory model never
  // sees a stray read or write while the latched address sits idle.
  assign mem_valid = (state == ACCESS);
  assign mem_wen   = mem_valid & wen_q;
  assign mem_raddr = mem_valid ? addr_q : '0;
  assign mem_waddr = mem_valid ? addr_q : '0;
  assign mem_wdata = mem_valid ? wdata_q : '0;
  assign mem_wmask = mem_valid ? wmask_q : '0;

  assign ifu_resp_valid = (state == RESP) & ~owner_lsu;
  assign lsu_resp_valid = (state == RESP) & owner_lsu;
  assign ifu_rdata      = ifu_resp_valid ? rdata_q : '0;
  assign lsu_rdata      = lsu_resp_valid ? rdata_q : '0;

  assign state_dbg = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Two arbiter instances: dut0 (LATENCY=1, round-robin) and dut1 (LATENCY=4,
// LSU priority). Tests run on one instance at a time, so one expected queue per
// event kind serves both. Drivers push expected grants, memory accesses and
// responses; a negedge monitor pops and compares whenever the DUT shows a
// handshake, a mem_valid pulse or a response transfer.
// Memory model: rdata = 0x00000413 at 0x80000000, otherwise addr ^ 0x5A5A0000.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int HS_W   = 2;   // {id, owner_lsu}
  localparam int MEM_W  = 74;  // {id, wen, addr, wdata, wmask}
  localparam int RESP_W = 34;  // {id, owner_lsu, rdata}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst            [2];
  logic        ifu_req_valid  [2];
  logic        ifu_req_ready  [2];
  logic [31:0] ifu_raddr      [2];
  logic        ifu_resp_valid [2];
  logic        ifu_resp_ready [2];
  logic [31:0] ifu_rdata      [2];
  logic        lsu_req_valid  [2];
  logic        lsu_req_ready  [2];
  logic        lsu_wen        [2];
  logic [31:0] lsu_addr       [2];
  logic [31:0] lsu_wdata      [2];
  logic [7:0]  lsu_wmask      [2];
  logic        lsu_resp_valid [2];
  logic        lsu_resp_ready [2];
  logic [31:0] lsu_rdata      [2];
  logic        mem_valid      [2];
  logic        mem_wen        [2];
  logic [31:0] mem_raddr      [2];
  logic [31:0] mem_waddr      [2];
  logic [31:0] mem_wdata      [2];
  logic [7:0]  mem_wmask      [2];
  logic [31:0] mem_rdata      [2];
  logic [1:0]  state_dbg      [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign mem_rdata[g] = (mem_raddr[g] == 32'h80000000) ? 32'h00000413
                                                         : (mem_raddr[g] ^ 32'h5A5A0000);
    mem_arbiter #(
      .LATENCY  (g == 0 ? 1 : 4),
      .LSU_PRIO (g == 0 ? 1'b0 : 1'b1)
    ) u_dut (
      .clk            (clk),
      .reset          (rst[g]),
      .ifu_req_valid  (ifu_req_valid[g]),
      .ifu_req_ready  (ifu_req_ready[g]),
      .ifu_raddr      (ifu_raddr[g]),
      .ifu_resp_valid (ifu_resp_valid[g]),
      .ifu_resp_ready (ifu_resp_ready[g]),
      .ifu_rdata      (ifu_rdata[g]),
      .lsu_req_valid  (lsu_req_valid[g]),
      .lsu_req_ready  (lsu_req_ready[g]),
      .lsu_wen        (lsu_wen[g]),
      .lsu_addr       (lsu_addr[g]),
      .lsu_wdata      (lsu_wdata[g]),
      .lsu_wmask      (lsu_wmask[g]),
      .lsu_resp_valid (lsu_resp_valid[g]),
      .lsu_resp_ready (lsu_resp_ready[g]),
      .lsu_rdata      (lsu_rdata[g]),
      .mem_valid      (mem_valid[g]),
      .mem_wen        (mem_wen[g]),
      .mem_raddr      (mem_raddr[g]),
      .mem_waddr      (mem_waddr[g]),
      .mem_wdata      (mem_wdata[g]),
      .mem_wmask      (mem_wmask[g]),
      .mem_rdata      (mem_rdata[g]),
      .state_dbg      (state_dbg[g])
    );
  end

  // ---------------- scoreboard state ----------------
  logic [HS_W-1:0]   exp_hs_q[$];
  logic [MEM_W-1:0]  exp_mem_q[$];
  logic [RESP_W-1:0] exp_resp_q[$];

  int          checks = 0;
  int          errors = 0;
  int          hs_cnt        [2] = '{0, 0};
  int          resp_cnt      [2] = '{0, 0};
  int          hs_cyc        [2] = '{0, 0};
  int          last_resp_cyc [2] = '{0, 0};
  bit          busy          [2] = '{1'b0, 1'b0};
  bit          prev_rv       [2] = '{1'b0, 1'b0};
  bit          prev_owner    [2] = '{1'b0, 1'b0};
  bit          b2b           [2] = '{1'b0, 1'b0};
  logic [31:0] prev_rdata    [2] = '{32'h0, 32'h0};

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s (dut%0d) @cyc %0d: got 0x%08h, expected 0x%08h",
               name, i, cyc, act, want);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic mon(input int i);
    logic [HS_W-1:0]   eh;
    logic [MEM_W-1:0]  em;
    logic [RESP_W-1:0] er;
    logic              hs_i, hs_l, rv, own;
    logic [31:0]       rd;
    if (rst[i]) begin
      busy[i]    = 1'b0;
      prev_rv[i] = 1'b0;
    end else begin
      hs_i = ifu_req_valid[i] & ifu_req_ready[i];
      hs_l = lsu_req_valid[i] & lsu_req_ready[i];
      chk("single_ready", i, {31'b0, ifu_req_ready[i] & lsu_req_ready[i]}, 32'h0);
      if (busy[i])
        chk("ready_while_busy", i, {30'b0, ifu_req_ready[i], lsu_req_ready[i]}, 32'h0);
      if (!mem_valid[i])
        chk("mem_quiet", i, mem_raddr[i] | mem_waddr[i] | mem_wdata[i] |
            {24'b0, mem_wmask[i]} | {31'b0, mem_wen[i]}, 32'h0);
      chk("resp_exclusive", i, {31'b0, ifu_resp_valid[i] & lsu_resp_valid[i]}, 32'h0);

      if (hs_i | hs_l) begin
        if (exp_hs_q.size() == 0) begin
          chk("unexpected_handshake", i, {31'b0, hs_i | hs_l}, 32'h0);
        end else begin
          eh = exp_hs_q.pop_front();
          chk("grant", i, {30'b0, i[0], hs_l}, {30'b0, eh});
          if (b2b[i]) chk("handshake_cycle", i, cyc, last_resp_cyc[i] + 1);
        end
        hs_cyc[i] = cyc;
        busy[i]   = 1'b1;
        hs_cnt[i]++;
      end

      if (mem_valid[i]) begin
        if (exp_mem_q.size() == 0) begin
          chk("unexpected_mem_access", i, {31'b0, mem_valid[i]}, 32'h0);
        end else begin
          em = exp_mem_q.pop_front();
          chk("mem_cycle", i, cyc, hs_cyc[i] + lat(i));
          chk("mem_wen", i, {31'b0, mem_wen[i]}, {31'b0, em[72]});
          chk("mem_raddr", i, mem_raddr[i], em[71:40]);
          chk("mem_waddr", i, mem_waddr[i], em[71:40]);
          if (em[72]) begin
            chk("mem_wdata", i, mem_wdata[i], em[39:8]);
            chk("mem_wmask", i, {24'b0, mem_wmask[i]}, {24'b0, em[7:0]});
          end
        end
      end

      rv  = ifu_resp_valid[i] | lsu_resp_valid[i];
      own = lsu_resp_valid[i];
      rd  = own ? lsu_rdata[i] : ifu_rdata[i];
      if (rv) begin
        if (prev_rv[i]) begin
          chk("resp_hold_owner", i, {31'b0, own}, {31'b0, prev_owner[i]});
          chk("resp_hold_rdata", i, rd, prev_rdata[i]);
        end else begin
          chk("resp_cycle", i, cyc, hs_cyc[i] + lat(i) + 1);
        end
        prev_rv[i]    = 1'b1;
        prev_owner[i] = own;
        prev_rdata[i] = rd;
        if (own ? lsu_resp_ready[i] : ifu_resp_ready[i]) begin
          if (exp_resp_q.size() == 0) begin
            chk("unexpected_response", i, {31'b0, rv}, 32'h0);
          end else begin
            er = exp_resp_q.pop_front();
            chk("resp_owner", i, {31'b0, own}, {31'b0, er[32]});
            chk("resp_rdata", i, rd, er[31:0]);
          end
          busy[i]          = 1'b0;
          prev_rv[i]       = 1'b0;
          last_resp_cyc[i] = cyc;
          resp_cnt[i]++;
        end
      end else begin
        prev_rv[i] = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) mon(i);
  end

  // ---------------- driver tasks (called just after a rising edge) ----------------
  task automatic expect_txn(input int i, input bit lsu, input bit wen,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [7:0] wmask, input logic [31:0] rdata);
    exp_hs_q.push_back({i[0], lsu});
    exp_mem_q.push_back({i[0], wen, addr, wdata, wmask});
    exp_resp_q.push_back({i[0], lsu, rdata});
  endtask

  task automatic request(input int i, input bit lsu, input bit wen,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [7:0] wmask, output int waited);
    int base;
    base = hs_cnt[i];
    if (lsu) begin
      lsu_wen[i] = wen; lsu_addr[i] = addr; lsu_wdata[i] = wdata; lsu_wmask[i] = wmask;
      lsu_req_valid[i] = 1'b1;
    end else begin
      ifu_raddr[i] = addr;
      ifu_req_valid[i] = 1'b1;
    end
    waited = 0;
    while (hs_cnt[i] == base && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("request_accepted", i, hs_cnt[i] - base, 32'd1);
    ifu_req_valid[i] = 1'b0;
    lsu_req_valid[i] = 1'b0;
  endtask

  task automatic wait_resp(input int i, input int target);
    int n;
    n = 0;
    while (resp_cnt[i] < target && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("response_count", i, resp_cnt[i], target);
  endtask

  task automatic txn(input int i, input bit lsu, input bit wen,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [7:0] wmask, input logic [31:0] rdata);
    int w, target;
    target = resp_cnt[i] + 1;
    expect_txn(i, lsu, wen, addr, wdata, wmask, rdata);
    request(i, lsu, wen, addr, wdata, wmask, w);
    wait_resp(i, target);
  endtask

  // Both requesters hold valid high until n handshakes have happened.
  task automatic tie(input int i, input int n, input logic [31:0] la, input logic [31:0] ia);
    int base, rbase, k;
    base = hs_cnt[i];
    rbase = resp_cnt[i];
    lsu_wen[i] = 1'b0; lsu_addr[i] = la; lsu_wdata[i] = '0; lsu_wmask[i] = '0;
    ifu_raddr[i] = ia;
    lsu_req_valid[i] = 1'b1;
    ifu_req_valid[i] = 1'b1;
    k = 0;
    while (hs_cnt[i] < base + n && k < 200) begin
      @(posedge clk); #1;
      k++;
      if (hs_cnt[i] > base) b2b[i] = 1'b1;
    end
    lsu_req_valid[i] = 1'b0;
    ifu_req_valid[i] = 1'b0;
    b2b[i] = 1'b0;
    chk("tie_handshakes", i, hs_cnt[i] - base, n);
    wait_resp(i, rbase + n);
  endtask

  task automatic chk_outputs_zero(input int i);
    chk("rst_handshake_outputs", i, {28'b0, ifu_req_ready[i], lsu_req_ready[i],
        ifu_resp_valid[i], lsu_resp_valid[i]}, 32'h0);
    chk("rst_ifu_rdata", i, ifu_rdata[i], 32'h0);
    chk("rst_lsu_rdata", i, lsu_rdata[i], 32'h0);
    chk("rst_mem", i, mem_raddr[i] | mem_waddr[i] | mem_wdata[i] | {24'b0, mem_wmask[i]} |
        {30'b0, mem_valid[i], mem_wen[i]}, 32'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w, target, base;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      ifu_req_valid[i] = 1'b0; ifu_raddr[i] = '0; ifu_resp_ready[i] = 1'b1;
      lsu_req_valid[i] = 1'b0; lsu_wen[i] = 1'b0; lsu_addr[i] = '0;
      lsu_wdata[i] = '0; lsu_wmask[i] = '0; lsu_resp_ready[i] = 1'b1;
    end
    @(posedge clk); @(posedge clk); @(negedge clk);
    for (int i = 0; i < 2; i++) chk_outputs_zero(i);
    @(posedge clk); #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // dut0: round-robin tie from reset -> LSU, IFU, LSU, IFU
    expect_txn(0, 1'b1, 1'b0, 32'h80002000, 32'h0, 8'h0, 32'hDA5A2000);
    expect_txn(0, 1'b0, 1'b0, 32'h80000004, 32'h0, 8'h0, 32'hDA5A0004);
    expect_txn(0, 1'b1, 1'b0, 32'h80002000, 32'h0, 8'h0, 32'hDA5A2000);
    expect_txn(0, 1'b0, 1'b0, 32'h80000004, 32'h0, 8'h0, 32'hDA5A0004);
    tie(0, 4, 32'h80002000, 32'h80000004);

    // dut0: single transactions
    txn(0, 1'b0, 1'b0, 32'h80000000, 32'h0, 8'h00, 32'h00000413);
    txn(0, 1'b1, 1'b1, 32'h80001000, 32'hDEADBEEF, 8'h0F, 32'h0);
    txn(0, 1'b1, 1'b0, 32'h80000010, 32'h0, 8'h00, 32'hDA5A0010);

    // dut1: LSU priority -> LSU granted every time
    for (int k = 0; k < 3; k++)
      expect_txn(1, 1'b1, 1'b0, 32'h80002000, 32'h0, 8'h0, 32'hDA5A2000);
    tie(1, 3, 32'h80002000, 32'h80000008);

    // dut1: LSU response stalled 3 cycles while IFU waits; IFU accepted right after
    target = resp_cnt[1] + 2;
    expect_txn(1, 1'b1, 1'b0, 32'h80003000, 32'h0, 8'h0, 32'hDA5A3000);
    expect_txn(1, 1'b0, 1'b0, 32'h80000000, 32'h0, 8'h0, 32'h00000413);
    base = hs_cnt[1];
    lsu_resp_ready[1] = 1'b0;
    lsu_wen[1] = 1'b0; lsu_addr[1] = 32'h80003000; ifu_raddr[1] = 32'h80000000;
    lsu_req_valid[1] = 1'b1;
    ifu_req_valid[1] = 1'b1;
    w = 0;
    while (hs_cnt[1] == base && w < 40) begin @(posedge clk); #1; w++; end
    lsu_req_valid[1] = 1'b0;
    b2b[1] = 1'b1;
    w = 0;
    while (!lsu_resp_valid[1] && w < 40) begin @(posedge clk); #1; w++; end
    chk("stall_resp_seen", 1, {31'b0, lsu_resp_valid[1]}, 32'h1);
    repeat (3) begin @(posedge clk); #1; end
    lsu_resp_ready[1] = 1'b1;
    w = 0;
    while (hs_cnt[1] < base + 2 && w < 40) begin @(posedge clk); #1; w++; end
    ifu_req_valid[1] = 1'b0;
    b2b[1] = 1'b0;
    wait_resp(1, target);

    // dut1: reset during WAIT drops the transaction; next request accepted at once
    exp_hs_q.push_back({1'b1, 1'b0});
    request(1, 1'b0, 1'b0, 32'h80000100, 32'h0, 8'h0, w);
    rst[1] = 1'b1;
    @(posedge clk); @(negedge clk);
    chk_outputs_zero(1);
    @(posedge clk); #1;
    rst[1] = 1'b0;
    target = resp_cnt[1] + 1;
    expect_txn(1, 1'b0, 1'b0, 32'h80000000, 32'h0, 8'h0, 32'h00000413);
    request(1, 1'b0, 1'b0, 32'h80000000, 32'h0, 8'h0, w);
    chk("accept_after_reset", 1, w, 32'd1);
    wait_resp(1, target);

    repeat (10) @(posedge clk);
    #1;
    chk("hs_queue_drained", 0, exp_hs_q.size(), 32'd0);
    chk("mem_queue_drained", 0, exp_mem_q.size(), 32'd0);
    chk("resp_queue_drained", 0, exp_resp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
